// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared types for the direct-mapped instruction cache
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  localparam int ICACHE_SETS    = 16;
  // Widest tag any legal SETS (>= 2) can need; narrower tags are zero-extended.
  localparam int ICACHE_TAG_MAX = 29;

  typedef struct packed {
    logic                      valid;
    logic [ICACHE_TAG_MAX-1:0] tag;
    word_t                     data;
  } icache_frame_t;

  typedef struct packed {
    logic [30-$clog2(ICACHE_SETS)-1:0] tag;
    logic [$clog2(ICACHE_SETS)-1:0]    idx;
    logic [1:0]                        bytoff;
  } icachef_t;

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } icache_state_t;

endpackage

// File: rtl/icache_frame_array.sv
// rtl/icache_frame_array.sv - SETS one-word frames, async read, single write port
module icache_frame_array
  import cpu_types_pkg::*;
#(
  parameter int SETS = 16
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [$clog2(SETS)-1:0]       rd_idx,
  output icache_frame_t                 rd_frame,
  input  logic                          wr_en,
  input  logic [$clog2(SETS)-1:0]       wr_idx,
  input  logic [30-$clog2(SETS)-1:0]    wr_tag,
  input  word_t                         wr_data
);

  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 30 - IDX_W;

  logic [SETS-1:0]  valid_q;
  logic [TAG_W-1:0] tag_q  [SETS];
  word_t            data_q [SETS];

  // Only the valid bits are reset; tag/data contents are don't-care until filled.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_idx] <= 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (wr_en) begin
      tag_q[wr_idx]  <= wr_tag;
      data_q[wr_idx] <= wr_data;
    end
  end

  always_comb begin
    rd_frame       = '0;
    rd_frame.valid = valid_q[rd_idx];
    rd_frame.tag   = ICACHE_TAG_MAX'(tag_q[rd_idx]);
    rd_frame.data  = data_q[rd_idx];
  end

endmodule

// File: rtl/icache_direct.sv
// rtl/icache_direct.sv - direct-mapped read-only I-cache with IDLE/FETCH miss FSM
// Optional hit/miss counters when ICACHE_STATS_EN is defined.
module icache_direct
  import cpu_types_pkg::*;
#(
  parameter int SETS = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 30 - IDX_W;

  icache_state_t    state_q;
  logic [29:0]      miss_addr_q;
  icache_frame_t    frame;
  logic [IDX_W-1:0] req_idx;
  logic [TAG_W-1:0] req_tag;
  logic             lookup_hit;
  logic             fill_en;
  logic [1:0]       unused_bytoff;

  assign req_idx       = imemaddr[IDX_W+1:2];
  assign req_tag       = imemaddr[31:IDX_W+2];
  assign unused_bytoff = imemaddr[1:0];

  icache_frame_array #(.SETS(SETS)) u_frames (
    .CLK      (CLK),
    .RST      (RST),
    .rd_idx   (req_idx),
    .rd_frame (frame),
    .wr_en    (fill_en),
    .wr_idx   (miss_addr_q[IDX_W-1:0]),
    .wr_tag   (miss_addr_q[29:IDX_W]),
    .wr_data  (iload)
  );

  assign lookup_hit = frame.valid && (frame.tag == ICACHE_TAG_MAX'(req_tag));
  assign ihit       = (state_q == IDLE) && imemREN && lookup_hit;
  assign imemload   = frame.valid ? frame.data : 32'h0;
  assign fill_en    = (state_q == FETCH) && !iwait;

  // iREN/iaddr come straight from registers so they are glitch-free and
  // drop the moment RST is asserted.
  assign iREN  = (state_q == FETCH);
  assign iaddr = {miss_addr_q, 2'b00};

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= IDLE;
      miss_addr_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (imemREN && !lookup_hit) begin
            miss_addr_q <= imemaddr[31:2];
            state_q     <= FETCH;
          end
        end
        FETCH: begin
          if (!iwait) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt_q;
  logic [31:0] miss_cnt_q;
  logic        miss_start;

  assign miss_start = (state_q == IDLE) && imemREN && !lookup_hit;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (ihit && (hit_cnt_q != 32'hFFFF_FFFF)) begin
        hit_cnt_q <= hit_cnt_q + 32'd1;
      end
      if (miss_start && (miss_cnt_q != 32'hFFFF_FFFF)) begin
        miss_cnt_q <= miss_cnt_q + 32'd1;
      end
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`endif

endmodule

// File: tb/tb_icache_direct.sv
// tb/tb_icache_direct.sv - directed self-checking bench for icache_direct
module tb_icache_direct;

  logic        CLK = 1'b0;
  logic        RST;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  always #5 CLK = ~CLK;

  icache_direct #(.SETS(16)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .imemREN    (imemREN),
    .imemaddr   (imemaddr),
    .ihit       (ihit),
    .imemload   (imemload),
    .iREN       (iREN),
    .iaddr      (iaddr),
    .iwait      (iwait),
    .iload      (iload)
`ifdef ICACHE_STATS_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Miss on addr, hold iwait high for `waits` FETCH cycles, then return data.
  task automatic fill(input logic [31:0] addr, input logic [31:0] data, input int waits);
    imemREN  = 1'b1;
    imemaddr = addr;
    iwait    = 1'b1;
    iload    = data;
    #1;
    chk("fill_detect_ihit", {31'd0, ihit}, 32'd0);
    chk("fill_detect_iren", {31'd0, iREN}, 32'd0);
    step();
    for (int i = 0; i < waits; i++) begin
      chk("fill_wait_iren", {31'd0, iREN}, 32'd1);
      chk("fill_wait_iaddr", iaddr, {addr[31:2], 2'b00});
      chk("fill_wait_ihit", {31'd0, ihit}, 32'd0);
      step();
    end
    iwait = 1'b0;
    #1;
    chk("fill_last_iren", {31'd0, iREN}, 32'd1);
    chk("fill_last_iaddr", iaddr, {addr[31:2], 2'b00});
    chk("fill_last_ihit", {31'd0, ihit}, 32'd0);
    step();
    iwait = 1'b1;
    #1;
    chk("fill_ret_ihit", {31'd0, ihit}, 32'd1);
    chk("fill_ret_load", imemload, data);
    chk("fill_ret_iren", {31'd0, iREN}, 32'd0);
  endtask

  initial begin
    RST      = 1'b1;
    imemREN  = 1'b0;
    imemaddr = 32'h0;
    iwait    = 1'b1;
    iload    = 32'h0;
    step();
    step();
    chk("rst_ihit", {31'd0, ihit}, 32'd0);
    chk("rst_iren", {31'd0, iREN}, 32'd0);
    chk("rst_iaddr", iaddr, 32'h0);
    chk("rst_imemload", imemload, 32'h0);
`ifdef ICACHE_STATS_EN
    chk("rst_hit_count", hit_count, 32'd0);
    chk("rst_miss_count", miss_count, 32'd0);
`endif
    RST = 1'b0;
    step();

    // Cold miss: 3 busy cycles + 1 completing cycle = 4 cycles of iREN.
    fill(32'h0000_0040, 32'h2001_0005, 3);
`ifdef ICACHE_STATS_EN
    chk("cold_miss_count", miss_count, 32'd1);
    chk("cold_hit_count", hit_count, 32'd0);
`endif

    // Hit after fill held for 5 cycles.
    for (int i = 0; i < 5; i++) begin
      chk("hit_ihit", {31'd0, ihit}, 32'd1);
      chk("hit_load", imemload, 32'h2001_0005);
      chk("hit_iren", {31'd0, iREN}, 32'd0);
      step();
    end
`ifdef ICACHE_STATS_EN
    chk("hit_count_5", hit_count, 32'd5);
    chk("hit_miss_count", miss_count, 32'd1);
`endif

    // Conflict: 0x80 shares idx 0 with 0x40, then 0x40 misses again.
    fill(32'h0000_0080, 32'hAAAA_0080, 1);
    fill(32'h0000_0040, 32'h2001_0005, 0);

    // Redirect mid-miss: iaddr holds 0x100 while imemaddr moves to 0x200.
    imemaddr = 32'h0000_0100;
    iload    = 32'h1111_0100;
    #1;
    chk("redir_detect_ihit", {31'd0, ihit}, 32'd0);
    step();
    imemaddr = 32'h0000_0200;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("redir_iren", {31'd0, iREN}, 32'd1);
      chk("redir_iaddr", iaddr, 32'h0000_0100);
      chk("redir_ihit", {31'd0, ihit}, 32'd0);
      step();
    end
    iwait = 1'b0;
    #1;
    chk("redir_last_iaddr", iaddr, 32'h0000_0100);
    step();
    iwait = 1'b1;
    #1;
    chk("redir_new_miss_ihit", {31'd0, ihit}, 32'd0);
    chk("redir_idle_iren", {31'd0, iREN}, 32'd0);
    imemaddr = 32'h0000_0100;
    #1;
    chk("redir_0x100_hit", {31'd0, ihit}, 32'd1);
    chk("redir_0x100_load", imemload, 32'h1111_0100);
    imemaddr = 32'h0000_0200;
    step();
    chk("redir_0x200_fetch_iren", {31'd0, iREN}, 32'd1);
    chk("redir_0x200_fetch_iaddr", iaddr, 32'h0000_0200);
    iwait = 1'b0;
    iload = 32'h2222_0200;
    step();
    iwait = 1'b1;
    #1;
    chk("redir_0x200_hit", {31'd0, ihit}, 32'd1);
    chk("redir_0x200_load", imemload, 32'h2222_0200);

    // Reset mid-FETCH: refill 0x40, start a miss on 0x84, pulse RST.
    fill(32'h0000_0040, 32'h2001_0005, 0);
    imemaddr = 32'h0000_0084;
    step();
    chk("rstmid_iren_before", {31'd0, iREN}, 32'd1);
    #2;
    RST = 1'b1;
    #1;
    chk("rstmid_iren_async", {31'd0, iREN}, 32'd0);
    chk("rstmid_ihit", {31'd0, ihit}, 32'd0);
    step();
    RST = 1'b0;
    imemaddr = 32'h0000_0040;
    #1;
    chk("rstmid_0x40_miss", {31'd0, ihit}, 32'd0);
    chk("rstmid_0x40_load", imemload, 32'h0);
    step();
    chk("rstmid_refetch_iren", {31'd0, iREN}, 32'd1);
    chk("rstmid_refetch_iaddr", iaddr, 32'h0000_0040);
    iwait = 1'b0;
    iload = 32'h2001_0005;
    step();
    iwait = 1'b1;
    #1;
    chk("rstmid_refill_hit", {31'd0, ihit}, 32'd1);

    // Low address bits ignored; imemREN low means no hit and no request.
    imemaddr = 32'h0000_0043;
    #1;
    chk("bytoff_hit", {31'd0, ihit}, 32'd1);
    chk("bytoff_load", imemload, 32'h2001_0005);
    imemREN  = 1'b0;
    imemaddr = 32'h0000_0300;
    #1;
    chk("halt_ihit", {31'd0, ihit}, 32'd0);
    step();
    step();
    chk("halt_iren", {31'd0, iREN}, 32'd0);
    imemaddr = 32'h0000_0040;
    #1;
    chk("halt_resident_ihit", {31'd0, ihit}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/icache_direct.md
Name: icache_direct

Overview:
- Direct-mapped, read-only instruction cache between the pipelined datapath's fetch port and the memory arbiter.
- Datapath side: serves imemaddr/imemREN and returns ihit/imemload.
- Memory side: on a miss, issues a single-word read (iREN/iaddr) and waits for iwait to drop.
- One-word blocks; fills occur only after a miss.

Parameters:
- SETS, 16, number of lines (power of two, 2..256).
- IDX_W, $clog2(SETS), index width; derived, not overridden.
- TAG_W, 30-IDX_W, tag width; derived, not overridden.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous active-high reset.
- imemREN  in  1  datapath fetch request.
- imemaddr  in  32  fetch byte address. [1:0] ignored, [IDX_W+1:2] index, [31:IDX_W+2] tag.
- ihit  out  1  imemload valid this cycle.
- imemload  out  32  instruction word.
- iREN  out  1  memory read request.
- iaddr  out  32  memory word address, [1:0]=00.
- iwait  in  1  memory busy; low = iload valid this cycle.
- iload  in  32  memory read data.

Behaviour:
- Storage: per set one valid bit, TAG_W tag and a 32-bit data word. All valid bits are cleared by RST. Tags and data are not reset.
- FSM states: IDLE, FETCH. Reset state IDLE.
- IDLE:
  - ihit = imemREN & valid[idx] & (tag[idx]==addr tag), combinational, same cycle.
  - imemload = data[idx] whenever valid[idx]. Otherwise 0.
  - On imemREN & !hit: latch {tag,idx} into miss_addr and go to FETCH next edge.
  - imemREN low: no state change, ihit=0.
- FETCH:
  - iREN=1 and iaddr={miss_addr,2'b00}. Both stay stable for the whole state.
  - ihit=0 throughout FETCH.
  - On an edge with iwait=0: write iload into data[miss idx], set the tag and valid bit, return to IDLE.
  - No same-cycle forwarding of iload. The retried fetch hits the cycle after return.
  - Miss penalty = 1 (detect) + N (memory wait cycles incl. final) + 1 (hit) cycles.
- Address change mid-FETCH (branch/jr redirect): the in-flight fill completes to the latched miss_addr. IDLE then re-evaluates the current imemaddr; a new mismatch triggers a new miss.
- imemREN dropped mid-FETCH (halt): the fill still completes, then the FSM idles.
- Aliasing: a fill overwrites the resident line unconditionally.
- RST asserted mid-FETCH: iREN drops immediately (asynchronously), FSM goes to IDLE, all valid bits clear, ihit=0.
- Reset values: ihit=0, iREN=0, iaddr=0, imemload=0.
- No write path. Self-modifying code is unsupported and has no invalidate input.

Optional Feature:
- Macro: ICACHE_STATS_EN.
- Defined:
  - Adds outputs hit_count[31:0] and miss_count[31:0], both reset to 0.
  - hit_count increments on each cycle with ihit=1.
  - miss_count increments on each IDLE->FETCH transition.
  - Both counters saturate at 32'hFFFF_FFFF.
- Undefined: neither port nor its counter logic exists. Functional behaviour is otherwise identical.

Decomposition:
- Add to cpu_types_pkg:
  - icache_frame_t {valid, tag[TAG_W-1:0], data word_t}.
  - icachef_t address split {tag, idx, bytoff[1:0]}.
  - enum icache_state_t {IDLE, FETCH}.
- One sub-module is natural: icache_frame_array. It is SETS frames with an async read port and a single write port, and clears valid bits on RST.
- The FSM and (optional) counters live in icache_direct.

Test Plan:
- Cold miss: RST, then imemREN=1, imemaddr=0x0000_0040, iwait=1 for 3 cycles then 0, iload=0x2001_0005 -> iREN high 4 cycles with iaddr=0x40. ihit=1 with imemload=0x2001_0005 the following cycle. miss_count=1.
- Hit after fill: re-request 0x40 for 5 cycles -> ihit=1 every cycle, iREN=0, hit_count +5.
- Conflict (SETS=16): fill 0x40, then fetch 0x80 (same idx 0, different tag) -> miss, iaddr=0x80. A subsequent 0x40 fetch misses again.
- Redirect mid-miss: miss on 0x100, change imemaddr to 0x200 during FETCH -> iaddr holds 0x100 until iwait=0. Then 0x200 misses, and later 0x100 hits.
- Reset mid-FETCH: assert RST while iREN=1 -> iREN=0 immediately. After release, previously filled 0x40 misses (valid cleared).
- Low address bits/halt: imemaddr=0x43 hits line 0x40. With imemREN=0 at any address -> ihit=0, no memory request.
